// File: rtl/smag_pkg.sv
// Shared types and constants for the sign-magnitude to BCD converter.
// Digit correction thresholds and default widths live here so sub-blocks agree.
package smag_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int BCD_ADJ_THRESH = 5;
   localparam int BCD_ADJ        = 3;

   localparam int DEF_MAG_W = 8;
   localparam int DEF_NDIG  = 3;

endpackage

// File: rtl/smag_bcd_conv_if.sv
// Product input and result output handshake bundle for smag_bcd_conv.
// slave is the converter side; master is the producer/consumer side.
interface smag_bcd_conv_if
   import smag_pkg::*;
#(
   parameter int MAG_W = DEF_MAG_W,
   parameter int NDIG  = DEF_NDIG
);

   logic                in_valid;
   logic                in_ready;
   logic                in_sign;
   logic [MAG_W-1:0]    in_mag;

   logic                out_valid;
   logic                out_ready;
   logic                out_sign;
   logic [4*NDIG-1:0]   out_bcd;
   logic [MAG_W:0]      out_tc;

   modport slave (
      input  in_valid, in_sign, in_mag, out_ready,
      output in_ready, out_valid, out_sign, out_bcd, out_tc
   );

   modport master (
      output in_valid, in_sign, in_mag, out_ready,
      input  in_ready, out_valid, out_sign, out_bcd, out_tc
   );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
// Purely combinational, no handshake.
module bcd_add3
   import smag_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t q
);

   assign q = (d >= 4'(BCD_ADJ_THRESH)) ? d + 4'(BCD_ADJ) : d;

endmodule

// File: rtl/smag_bcd_conv.sv
// Sign-magnitude product to BCD + two's complement, one double-dabble step per cycle.
// Result after MAG_W cycles; held in DONE until out_ready, no input taken while busy.
module smag_bcd_conv
   import smag_pkg::*;
#(
   parameter int MAG_W = DEF_MAG_W,
   parameter int NDIG  = DEF_NDIG
)
(
   input  logic             clk,
   input  logic             rst,
   smag_bcd_conv_if.slave   io
);

   localparam int BCD_W = 4 * NDIG;
   localparam int CNT_W = $clog2(MAG_W + 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [MAG_W-1:0]   mag_sr;
   logic [BCD_W-1:0]   bcd_acc;
   logic [BCD_W-1:0]   bcd_adj;
   logic               sign_q;
   logic [MAG_W:0]     tc_q;
   logic               accept;
   logic               last_shift;
   logic               sign_norm;
   logic [MAG_W:0]     mag_ext;
   logic [MAG_W:0]     tc_nxt;

   for (genvar g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d (bcd_acc[4*g +: 4]),
         .q (bcd_adj[4*g +: 4])
      );
   end

   assign last_shift = (cnt == CNT_W'(MAG_W - 1));

   // "-0" collapses to +0 so the readout never shows a negative zero
   assign sign_norm = io.in_sign && (|io.in_mag);
   assign mag_ext   = {1'b0, io.in_mag};
   assign tc_nxt    = sign_norm ? -mag_ext : mag_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      accept       = 1'b0;
      case (state)
         IDLE: begin
            io.in_ready = 1'b1;
            if (io.in_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_shift) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            io.out_valid = 1'b1;
            if (io.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         mag_sr  <= '0;
         bcd_acc <= '0;
         sign_q  <= 1'b0;
         tc_q    <= '0;
      end else if (accept) begin
         cnt     <= '0;
         mag_sr  <= io.in_mag;
         bcd_acc <= '0;
         sign_q  <= sign_norm;
         tc_q    <= tc_nxt;
      end else if (state == SHIFT) begin
         // correct first, then shift the magnitude MSB into the BCD LSB
         {bcd_acc, mag_sr} <= {bcd_adj, mag_sr} << 1;
         cnt               <= cnt + CNT_W'(1);
      end
   end

   assign io.out_sign = sign_q;
   assign io.out_bcd  = bcd_acc;
   assign io.out_tc   = tc_q;

endmodule

// File: tb/tb_smag_bcd_conv.sv
// Scoreboard bench for smag_bcd_conv: expected results queued at drive time,
// compared when the converter presents a result.
module tb_smag_bcd_conv;

   localparam int MAG_W = 8;
   localparam int NDIG  = 3;

   typedef struct {
      logic        sign;
      logic [11:0] bcd;
      logic [8:0]  tc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_chk = 0;
   int n_err = 0;
   exp_t sb[$];

   smag_bcd_conv_if #(.MAG_W(MAG_W), .NDIG(NDIG)) io ();

   smag_bcd_conv #(.MAG_W(MAG_W), .NDIG(NDIG)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic s, input logic [7:0] m);
      exp_t e;
      int   v;
      v = int'(m);
      e.sign = s && (v != 0);
      e.bcd[11:8] = 4'(v / 100);
      e.bcd[7:4]  = 4'((v / 10) % 10);
      e.bcd[3:0]  = 4'(v % 10);
      e.tc = e.sign ? 9'((512 - v) % 512) : 9'(v);
      return e;
   endfunction

   task automatic run_one(input logic s, input logic [7:0] m, input int hold, input bit busy);
      exp_t e;
      int   lat;
      e = model(s, m);
      sb.push_back(e);
      chk("rdy_before_accept", 32'(io.in_ready), 32'd1);
      io.in_sign   = s;
      io.in_mag    = m;
      io.in_valid  = 1'b1;
      io.out_ready = 1'b0;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      chk("rdy_after_accept", 32'(io.in_ready), 32'd0);
      chk("vld_after_accept", 32'(io.out_valid), 32'd0);
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         if (busy) begin
            io.in_valid = k[0];
            io.in_sign  = ~s;
            io.in_mag   = ~m ^ 8'(k);
         end
         @(posedge clk); #1;
         if (io.out_valid) lat = k;
      end
      io.in_valid = 1'b0;
      if (lat == 0) begin
         chk("timeout_out_valid", 32'd0, 32'd1);
         void'(sb.pop_front());
         return;
      end
      chk("latency", 32'(lat), 32'(MAG_W));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_vld", 32'(io.out_valid), 32'd1);
         chk("hold_rdy", 32'(io.in_ready), 32'd0);
         chk("hold_bcd", 32'(io.out_bcd), 32'(e.bcd));
         chk("hold_tc", 32'(io.out_tc), 32'(e.tc));
      end
      io.out_ready = 1'b1;
      e = sb.pop_front();
      chk("out_sign", 32'(io.out_sign), 32'(e.sign));
      chk("out_bcd", 32'(io.out_bcd), 32'(e.bcd));
      chk("out_tc", 32'(io.out_tc), 32'(e.tc));
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      chk("vld_after_hs", 32'(io.out_valid), 32'd0);
      chk("rdy_after_hs", 32'(io.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog n_chk=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      io.in_valid  = 1'b0;
      io.in_sign   = 1'b0;
      io.in_mag    = '0;
      io.out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 32'(io.in_ready), 32'd1);
      chk("rst_out_valid", 32'(io.out_valid), 32'd0);
      chk("rst_out_sign", 32'(io.out_sign), 32'd0);
      chk("rst_out_bcd", 32'(io.out_bcd), 32'd0);
      chk("rst_out_tc", 32'(io.out_tc), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_one(1'b0, 8'h37, 0, 1'b0);
      run_one(1'b1, 8'hE1, 0, 1'b0);
      run_one(1'b1, 8'h00, 0, 1'b0);
      run_one(1'b0, 8'hFF, 5, 1'b0);
      run_one(1'b1, 8'h63, 0, 1'b1);

      // abort a conversion in its 4th SHIFT cycle
      io.in_sign  = 1'b0;
      io.in_mag   = 8'h99;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(io.in_ready), 32'd1);
      chk("midrst_out_bcd", 32'(io.out_bcd), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_one(1'b0, 8'h50, 0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_one(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), i % 3, 1'(i % 2));
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
